// File: rtl/data_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_link_pkg
// Description : Constants shared by both ends of the 2-bit <-> 8-bit link so
//               transmitter and receiver agree on symbols per word.
// Revision    : 1.0 - initial release
// ============================================================================
package data_link_pkg;

   localparam int DIN_W_DEF    = 8;
   localparam int DOUT_W_DEF   = 2;
   localparam int SYM_PER_WORD = DIN_W_DEF / DOUT_W_DEF;
   localparam int CNT_W        = $clog2(SYM_PER_WORD + 1);

   // The counter must hold the full value N as well as zero.
   function automatic int cnt_width(input int din_w, input int dout_w);
      return $clog2((din_w / dout_w) + 1);
   endfunction

   function automatic bit width_ok(input int din_w, input int dout_w);
      return (dout_w > 0) && ((din_w % dout_w) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_split_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : data_split_hold_buf
// Description : One-entry holding register; a load wins over a drain.
// Revision    : 1.0 - initial release
// ============================================================================
module data_split_hold_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         drain_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         valid_o
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/data_split.sv
`default_nettype none
// ============================================================================
// Module      : data_split
// Description : Parallel-to-serial transmitter, MSB-first symbols, with a
//               one-word holding buffer for gapless back-to-back words.
// Revision    : 1.0 - initial release
// ============================================================================
module data_split
   import data_link_pkg::*;
#(
   parameter int DIN_W  = DIN_W_DEF,
   parameter int DOUT_W = DOUT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIN_W-1:0]  din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [DOUT_W-1:0] dout,
   output logic              dout_en,
   output logic              dout_last,
   output logic              busy
);

   localparam int                N     = DIN_W / DOUT_W;
   localparam int                CNT_W = cnt_width(DIN_W, DOUT_W);
   localparam logic [CNT_W-1:0]  C_N   = CNT_W'(N);

   if (!width_ok(DIN_W, DOUT_W)) begin : g_width_chk
      $error("data_split: DIN_W must be an integer multiple of DOUT_W");
   end

   logic [DIN_W-1:0] sh_data_q, sh_data_d;
   logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d;
   logic [DIN_W-1:0] w_hold_data;
   logic             w_hold_valid;
   logic             w_active;
   logic             w_last;
   logic             w_free;
   logic             w_accept;
   logic             w_hold_load;
   logic             w_hold_drain;

   assign w_active = (sh_cnt_q != '0);
   assign w_last   = w_active && (sh_cnt_q == CNT_W'(1));
   // The shifter can take a new word on the edge that retires its last symbol.
   assign w_free   = !w_active || w_last;
   assign w_accept = din_valid && din_ready;

   // Hold is drained first, so a word arriving alongside a drain must queue.
   assign w_hold_drain = w_free && w_hold_valid;
   assign w_hold_load  = w_accept && (!w_free || w_hold_valid);

   data_split_hold_buf #(
      .W (DIN_W)
   ) u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (w_hold_load),
      .drain_i (w_hold_drain),
      .data_i  (din),
      .data_o  (w_hold_data),
      .valid_o (w_hold_valid)
   );

   always_comb begin
      sh_data_d = sh_data_q;
      sh_cnt_d  = sh_cnt_q;
      if (w_free && w_hold_valid) begin
         sh_data_d = w_hold_data;
         sh_cnt_d  = C_N;
      end else if (w_free && w_accept) begin
         sh_data_d = din;
         sh_cnt_d  = C_N;
      end else if (w_active) begin
         sh_data_d = sh_data_q << DOUT_W;
         sh_cnt_d  = sh_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_data_q <= '0;
         sh_cnt_q  <= '0;
      end else begin
         sh_data_q <= sh_data_d;
         sh_cnt_q  <= sh_cnt_d;
      end
   end

   assign dout      = sh_data_q[DIN_W-1 -: DOUT_W];
   assign dout_en   = w_active;
   assign dout_last = w_last;
   assign din_ready = !w_hold_valid && !rst;
   assign busy      = w_active || w_hold_valid;

endmodule
`default_nettype wire

// File: tb/tb_data_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_split
// Description : Directed self-checking bench for data_split with a behavioural
//               2-bit -> 8-bit receiver on the serial side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_split;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        din_ready;
   logic [1:0]  dout;
   logic        dout_en;
   logic        dout_last;
   logic        busy;

   logic [15:0] v_din;
   logic        v_din_valid;
   logic        v_din_ready;
   logic [3:0]  v_dout;
   logic        v_dout_en;
   logic        v_dout_last;
   logic        v_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   data_split dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .dout      (dout),
      .dout_en   (dout_en),
      .dout_last (dout_last),
      .busy      (busy)
   );

   data_split #(
      .DIN_W  (16),
      .DOUT_W (4)
   ) dut_w16 (
      .clk       (clk),
      .rst       (rst),
      .din       (v_din),
      .din_valid (v_din_valid),
      .din_ready (v_din_ready),
      .dout      (v_dout),
      .dout_en   (v_dout_en),
      .dout_last (v_dout_last),
      .busy      (v_busy)
   );

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Receiver model: collects four symbols per byte, realigns on reset.
   logic [7:0] rx_sh = 8'h00;
   int         rx_n  = 0;
   logic [7:0] rx_q[$];
   int         cyc      = 0;
   int         en_cnt   = 0;
   int         en_first = -1;
   int         en_last  = -1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         rx_n = 0;
      end else if (dout_en) begin
         rx_sh = {rx_sh[5:0], dout};
         en_cnt++;
         if (en_first < 0) en_first = cyc;
         en_last = cyc;
         if (rx_n == 3) begin
            rx_q.push_back(rx_sh);
            rx_n = 0;
         end else begin
            rx_n++;
         end
      end
   end

   task automatic send(input logic [7:0] w);
      int guard;
      bit idle;
      guard     = 0;
      din       = w;
      din_valid = 1'b1;
      while (!din_ready && guard < 20) begin
         tick;
         guard++;
      end
      if (guard >= 20) chk_val("ready_timeout", 32'd0, 32'd1);
      idle = !busy;
      tick;
      din_valid = 1'b0;
      din       = ~w;
      if (idle) begin
         chk_val("idle_latency_en", dout_en, 1);
         chk_val("idle_first_sym", dout, w[7:6]);
      end
   endtask

   logic [7:0] bb_words [3]  = '{8'hB4, 8'h1E, 8'hFF};
   logic [1:0] bb_sym   [12] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2,
                                 2'd3, 2'd3, 2'd3, 2'd3};
   logic       bb_rdy   [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1};
   logic [7:0] gap_words[8]  = '{8'h00, 8'h81, 8'h5A, 8'hC3, 8'h7E, 8'h01, 8'hF0, 8'h96};
   logic [1:0] sw_sym   [4]  = '{2'd2, 2'd3, 2'd1, 2'd0};
   logic [1:0] rs_sym   [4]  = '{2'd1, 2'd1, 2'd2, 2'd2};
   logic [3:0] v_sym    [4]  = '{4'hC, 4'h3, 4'hA, 4'h5};
   int         idx;
   bit         acc;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      din         = 8'h00;
      din_valid   = 1'b0;
      v_din       = 16'h0000;
      v_din_valid = 1'b0;
      tick;
      tick;

      chk_val("rst_dout_en", dout_en, 0);
      chk_val("rst_dout", dout, 0);
      chk_val("rst_dout_last", dout_last, 0);
      chk_val("rst_busy", busy, 0);
      chk_val("rst_din_ready", din_ready, 0);
      rst = 1'b0;
      #1;
      chk_val("post_rst_ready", din_ready, 1);

      // Single word while idle
      rx_q.delete();
      din       = 8'hB4;
      din_valid = 1'b1;
      tick;
      din_valid = 1'b0;
      din       = 8'h00;
      for (int i = 0; i < 4; i++) begin
         chk_val("sw_en", dout_en, 1);
         chk_val("sw_sym", dout, sw_sym[i]);
         chk_val("sw_last", dout_last, (i == 3));
         chk_val("sw_busy", busy, 1);
         tick;
      end
      chk_val("sw_en_after", dout_en, 0);
      chk_val("sw_dout_after", dout, 0);
      chk_val("sw_last_after", dout_last, 0);
      chk_val("sw_busy_after", busy, 0);

      // Back-to-back words with valid held high
      idx       = 0;
      din       = bb_words[0];
      din_valid = 1'b1;
      acc       = din_valid && din_ready;
      tick;
      if (acc) begin
         idx++;
         din = bb_words[idx];
      end
      for (int i = 0; i < 12; i++) begin
         chk_val("bb_en", dout_en, 1);
         chk_val("bb_sym", dout, bb_sym[i]);
         chk_val("bb_ready", din_ready, bb_rdy[i]);
         chk_val("bb_last", dout_last, ((i % 4) == 3));
         acc = din_valid && din_ready;
         tick;
         if (acc) begin
            idx++;
            if (idx < 3) din = bb_words[idx];
            else din_valid = 1'b0;
         end
      end
      chk_val("bb_en_after", dout_en, 0);
      chk_val("bb_busy_after", busy, 0);
      chk_val("bb_words_taken", idx, 3);
      chk_val("bb_rx_count", rx_q.size(), 4);
      if (rx_q.size() == 4) begin
         chk_val("bb_rx0", rx_q[0], 8'hB4);
         chk_val("bb_rx1", rx_q[1], 8'hB4);
         chk_val("bb_rx2", rx_q[2], 8'h1E);
         chk_val("bb_rx3", rx_q[3], 8'hFF);
      end

      // Words separated by random idle gaps
      rx_q.delete();
      for (int i = 0; i < 8; i++) begin
         send(gap_words[i]);
         repeat ($urandom_range(0, 6)) tick;
      end
      repeat (8) tick;
      chk_val("gap_rx_count", rx_q.size(), 8);
      for (int i = 0; i < 8 && i < rx_q.size(); i++) chk_val("gap_rx_byte", rx_q[i], gap_words[i]);

      // Reset in the middle of a word with another word held
      rx_q.delete();
      din       = 8'hA5;
      din_valid = 1'b1;
      tick;
      din = 8'h3C;
      tick;
      din_valid = 1'b0;
      chk_val("mr_sym1", dout, 2'b10);
      chk_val("mr_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk_val("mr_ready_in_rst", din_ready, 0);
      tick;
      chk_val("mr_en_after_rst", dout_en, 0);
      chk_val("mr_ready_after_rst", din_ready, 0);
      chk_val("mr_busy_after_rst", busy, 0);
      chk_val("mr_dout_after_rst", dout, 0);
      rst = 1'b0;
      #1;
      din       = 8'h5A;
      din_valid = 1'b1;
      tick;
      din_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_val("mr_new_en", dout_en, 1);
         chk_val("mr_new_sym", dout, rs_sym[i]);
         tick;
      end
      chk_val("mr_new_en_after", dout_en, 0);
      chk_val("mr_rx_count", rx_q.size(), 1);
      if (rx_q.size() == 1) chk_val("mr_rx_byte", rx_q[0], 8'h5A);

      // Loopback of every byte value back-to-back
      rx_q.delete();
      en_cnt   = 0;
      en_first = -1;
      en_last  = -1;
      for (int i = 0; i < 256; i++) send(8'(i));
      repeat (8) tick;
      chk_val("lb_rx_count", rx_q.size(), 256);
      for (int i = 0; i < 256 && i < rx_q.size(); i++) chk_val("lb_rx_byte", rx_q[i], 32'(i));
      chk_val("lb_en_cycles", en_cnt, 1024);
      chk_val("lb_en_contiguous", en_last - en_first + 1, 1024);

      // 16-bit word, 4-bit symbols
      v_din       = 16'hC3A5;
      v_din_valid = 1'b1;
      tick;
      v_din_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_val("w16_en", v_dout_en, 1);
         chk_val("w16_sym", v_dout, v_sym[i]);
         chk_val("w16_last", v_dout_last, (i == 3));
         tick;
      end
      chk_val("w16_en_after", v_dout_en, 0);
      chk_val("w16_busy_after", v_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
